// File: rtl/wave_capture.sv
// wave_capture: triggered oscilloscope capture into a double-buffered sample RAM.
// Arms on a rising zero crossing and writes 256 offset-binary samples into the
// buffer half the display is not reading. After the capture it waits for display
// blanking, then swaps halves.
// Optional feature macro: WAVE_CAPTURE_TIMEOUT_EN. When it is defined, a capture
// is forced after TIMEOUT_SAMPLES samples arrive in ARMED without a crossing.
module wave_capture #(
    parameter int unsigned TIMEOUT_SAMPLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    input  logic        wave_display_idle,
    output logic [8:0]  write_address,
    output logic        write_enable,
    output logic [7:0]  write_sample,
    output logic        read_index
);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [7:0]  offset, offset_next;
    logic        prev_neg, prev_neg_next;
    logic        read_index_next;
    logic        write_enable_next;
    logic [8:0]  write_address_next;
    logic [7:0]  write_sample_next;
    logic [7:0]  sample_offset_binary;
    logic        crossing;
    logic        trigger;

    // The low byte is below the 8-bit display resolution.
    logic        unused_low_bits;
    assign unused_low_bits = ^new_sample_in[7:0];

    // Top byte with the sign bit flipped maps signed samples onto 0..255.
    assign sample_offset_binary = {~new_sample_in[15], new_sample_in[14:8]};
    assign crossing             = prev_neg & ~new_sample_in[15];

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_SAMPLES + 1);

    logic [TIMEOUT_W-1:0] timeout_count, timeout_count_next;
    logic                 timeout_hit;

    assign timeout_hit = (timeout_count == TIMEOUT_W'(TIMEOUT_SAMPLES));
    assign trigger     = crossing | timeout_hit;
`else
    localparam int unsigned unused_timeout_samples = TIMEOUT_SAMPLES;

    assign trigger = crossing;
`endif

    // Next-state, buffer control and RAM write-port decode.
    always_comb begin
        state_next         = state;
        offset_next        = offset;
        prev_neg_next      = prev_neg;
        read_index_next    = read_index;
        write_enable_next  = 1'b0;
        write_address_next = write_address;
        write_sample_next  = write_sample;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        timeout_count_next = timeout_count;
`endif

        if (new_sample_ready) begin
            prev_neg_next = new_sample_in[15];
        end

        case (state)
            ARMED: begin
                if (new_sample_ready) begin
                    if (trigger) begin
                        write_enable_next  = 1'b1;
                        write_address_next = {~read_index, 8'h00};
                        write_sample_next  = sample_offset_binary;
                        offset_next        = 8'd1;
                        state_next         = ACTIVE;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
                        timeout_count_next = '0;
`endif
                    end else begin
`ifdef WAVE_CAPTURE_TIMEOUT_EN
                        timeout_count_next = timeout_count + TIMEOUT_W'(1);
`endif
                    end
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    write_enable_next  = 1'b1;
                    write_address_next = {~read_index, offset};
                    write_sample_next  = sample_offset_binary;
                    offset_next        = offset + 8'd1;
                    if (offset == 8'hFF) begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wave_display_idle) begin
                    read_index_next = ~read_index;
                    state_next      = ARMED;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
                    timeout_count_next = '0;
`endif
                end
            end
            default: begin
                state_next = ARMED;
            end
        endcase
    end

    // State and registered outputs; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ARMED;
            offset        <= 8'd0;
            prev_neg      <= 1'b0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= 9'd0;
            write_sample  <= 8'd0;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
            timeout_count <= '0;
`endif
        end else begin
            state         <= state_next;
            offset        <= offset_next;
            prev_neg      <= prev_neg_next;
            read_index    <= read_index_next;
            write_enable  <= write_enable_next;
            write_address <= write_address_next;
            write_sample  <= write_sample_next;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
            timeout_count <= timeout_count_next;
`endif
        end
    end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 Parameter TIMEOUT_SAMPLES, default 1024, number of ARMED samples without trigger before forced capture (used only under REQ-024).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 new_sample_ready  input  1  one-cycle strobe, new_sample_in valid this cycle.
REQ-005 new_sample_in  input  16  signed two's-complement audio sample.
REQ-006 wave_display_idle  input  1  high while the downstream display is in vertical blanking.
REQ-007 write_address  output  9  RAM write address {buffer, offset[7:0]}.
REQ-008 write_enable  output  1  one-cycle RAM write strobe.
REQ-009 write_sample  output  8  unsigned sample written to RAM.
REQ-010 read_index  output  1  buffer half the display reads; capture writes the other half.

Function
REQ-011 State machine SHALL have exactly three states: ARMED, ACTIVE, WAIT.
REQ-012 Block SHALL keep prev_neg, set to new_sample_in[15] on every new_sample_ready in all states.
REQ-013 ARMED: on new_sample_ready with prev_neg=1 and new_sample_in[15]=0 (rising zero crossing) SHALL write that sample at offset 0 and go ACTIVE with offset counter=1.
REQ-014 ACTIVE: each new_sample_ready SHALL write the sample at the current offset and increment offset; the write at offset 255 SHALL move state to WAIT and wrap offset to 0.
REQ-015 WAIT: new_sample_ready SHALL cause no write; first cycle with wave_display_idle=1 SHALL toggle read_index and return to ARMED.
REQ-016 wave_display_idle SHALL be ignored in ARMED and ACTIVE; idle high in the same cycle as the ACTIVE->WAIT transition SHALL not toggle read_index until sampled in WAIT (next cycle at earliest).
REQ-017 write_address SHALL be {~read_index, offset}, using read_index as of the sample cycle.
REQ-018 write_sample SHALL be new_sample_in[15:8] with bit 7 inverted (offset-binary: -32768 -> 8'h00, 0 -> 8'h80, 32767 -> 8'hFF).
REQ-019 write_enable, write_address, write_sample SHALL be registered: one-cycle latency from the accepted new_sample_ready; write_enable high exactly one cycle per write.
REQ-020 Block SHALL write exactly 256 samples per capture, to consecutive offsets 0..255 in one buffer half, never to the half selected by read_index.

Reset
REQ-021 Reset SHALL take priority over all inputs in the same cycle.
REQ-022 Reset values: state=ARMED, offset=0, prev_neg=0, read_index=0, write_enable=0, write_address=0, write_sample=0, timeout counter=0.
REQ-023 Reset mid-ACTIVE SHALL abandon the capture; no further write until a new trigger.

Configuration
REQ-024 Macro WAVE_CAPTURE_TIMEOUT_EN defined: ARMED SHALL count accepted samples; when TIMEOUT_SAMPLES samples pass without a crossing, the next new_sample_ready SHALL be treated as a trigger (REQ-013); counter clears on any entry to ARMED and on trigger.
REQ-025 Macro undefined: no timeout logic; ARMED waits for a crossing indefinitely (DC input never captures).

Verification
REQ-026 Reset, then samples -100, +100 -> write_enable one cycle after +100 strobe, write_address=9'h100, write_sample=8'h80, state ACTIVE.
REQ-027 Trigger then 255 further strobes with ramp -> addresses 9'h100..9'h1FF in order, 256 writes total, 257th strobe produces no write.
REQ-028 In WAIT assert wave_display_idle one cycle -> read_index 0->1 next cycle; next capture writes 9'h000..9'h0FF.
REQ-029 Samples 16'h8000, 16'h7FFF, 16'h0000 on capture -> write_sample 8'h00, 8'hFF, 8'h80.
REQ-030 Reset asserted at offset 100 in ACTIVE -> write_enable 0, read_index 0, next write only after new -/+ crossing, at offset 0.
REQ-031 With WAVE_CAPTURE_TIMEOUT_EN, TIMEOUT_SAMPLES=8, constant +500 input -> capture starts on 9th strobe; without macro, no write after 2000 strobes.
